// File: rtl/alu4_pkg.sv
// rtl/alu4_pkg.sv - shared types and constants for the alu4 issue stage
//
// Contents:
//   ALU_WIDTH  datapath width of the alu4 block
//   alu_op_t   operation encoding on the alu4 op pins
//   cmd_t      one queued command {op, a, b, use_acc}
//   state_t    issue FSM states
package alu4_pkg;

    localparam int ALU_WIDTH = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } alu_op_t;

    typedef struct packed {
        alu_op_t                op;
        logic [ALU_WIDTH-1:0]   a;
        logic [ALU_WIDTH-1:0]   b;
        logic                   use_acc;
    } cmd_t;

    // IDLE: operand register empty; ISSUE: operands on the alu pins;
    // STALL: operands held because the result register cannot take them.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        STALL = 2'd2
    } state_t;

endpackage

// File: rtl/alu4_cmd_fifo.sv
// rtl/alu4_cmd_fifo.sv - synchronous command FIFO carrying cmd_t entries
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, push_data   write request and entry (ignored when full)
//   pop, pop_data     read request (ignored when empty), head entry
//   full, empty       occupancy flags derived from a registered count
module alu4_cmd_fifo
    import alu4_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t pop_data,
    output logic full,
    output logic empty
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C = FIFO_DEPTH[PW:0];

    cmd_t          mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu4_issue_stage.sv
// rtl/alu4_issue_stage.sv - command sequencer feeding the combinational alu4
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake; cmd_op/cmd_a/cmd_b/cmd_use_acc
//   alu_a/alu_b/alu_op            operands driven to alu4
//   alu_result/alu_ovf            alu4 outputs, captured into the result register
//   res_valid/res_ready           result handshake; res_data/res_ovf
//   acc                           last captured result
//   sticky_ovf/clr_sticky         accumulated overflow flag and its clear
module alu4_issue_stage
    import alu4_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [ALU_WIDTH-1:0] cmd_a,
    input  logic [ALU_WIDTH-1:0] cmd_b,
    input  logic                 cmd_use_acc,
    output logic [ALU_WIDTH-1:0] alu_a,
    output logic [ALU_WIDTH-1:0] alu_b,
    output logic [1:0]           alu_op,
    input  logic [ALU_WIDTH-1:0] alu_result,
    input  logic                 alu_ovf,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ALU_WIDTH-1:0] res_data,
    output logic                 res_ovf,
    output logic [ALU_WIDTH-1:0] acc,
    output logic                 sticky_ovf,
    input  logic                 clr_sticky
);

    cmd_t                 in_cmd;
    cmd_t                 head;
    cmd_t                 opr;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 capture;
    logic                 out_free;
    logic                 ovf_now;
    logic [ALU_WIDTH-1:0] acc_fwd;
    state_t               state;
    state_t               state_next;

    assign in_cmd    = {alu_op_t'(cmd_op), cmd_a, cmd_b, cmd_use_acc};
    // Held low while rst is asserted so nothing is accepted into a FIFO being cleared.
    assign cmd_ready = !full && !rst;
    assign push      = cmd_valid && cmd_ready;
    assign out_free  = !res_valid || res_ready;
    assign ovf_now   = (opr.op == OP_ADD) && alu_ovf;
    // A command popped on a capture edge must see the result being written to acc.
    assign acc_fwd   = capture ? alu_result : acc;

    assign alu_a  = opr.a;
    assign alu_b  = opr.b;
    assign alu_op = opr.op;

    alu4_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_cmd),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE, STALL: begin
                if (out_free) begin
                    capture = 1'b1;
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    state_next = STALL;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand register: only a pop changes it, so the alu pins stay put when idle or stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            opr <= '{op: OP_ADD, a: '0, b: '0, use_acc: 1'b0};
        end else if (pop) begin
            opr.op      <= head.op;
            opr.a       <= head.use_acc ? acc_fwd : head.a;
            opr.b       <= head.b;
            opr.use_acc <= head.use_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_ovf    <= 1'b0;
            acc        <= '0;
            sticky_ovf <= 1'b0;
        end else begin
            if (capture) begin
                res_valid <= 1'b1;
                res_data  <= alu_result;
                res_ovf   <= ovf_now;
                acc       <= alu_result;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
            // A new overflow outranks a clear in the same cycle.
            if (capture && ovf_now) begin
                sticky_ovf <= 1'b1;
            end else if (clr_sticky) begin
                sticky_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu4_issue_stage.sv
// tb/tb_alu4_issue_stage.sv - scoreboard testbench for alu4_issue_stage
module tb_alu4_issue_stage;
    import alu4_pkg::*;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic       cmd_use_acc;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_op;
    logic [3:0] alu_result;
    logic       alu_ovf;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic       res_ovf;
    logic [3:0] acc;
    logic       sticky_ovf;
    logic       clr_sticky;

    int passed = 0;
    int total  = 0;
    logic [4:0] exp_q [$];

    alu4_issue_stage #(.FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_use_acc (cmd_use_acc),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_ovf     (alu_ovf),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_ovf     (res_ovf),
        .acc         (acc),
        .sticky_ovf  (sticky_ovf),
        .clr_sticky  (clr_sticky)
    );

    // alu4 stand-in: carry out on ADD, borrow on SUB, and a raw overflow of 1 on
    // AND/OR, so the stage's ADD-only overflow masking is visible.
    always_comb begin
        alu_result = 4'h0;
        alu_ovf    = 1'b0;
        case (alu_op)
            2'd0: {alu_ovf, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            2'd1: begin alu_result = alu_a - alu_b; alu_ovf = (alu_a < alu_b); end
            2'd2: begin alu_result = alu_a & alu_b; alu_ovf = 1'b1; end
            default: begin alu_result = alu_a | alu_b; alu_ovf = 1'b1; end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every result handshake is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                check("res_data", int'(res_data), int'(e[3:0]));
                check("res_ovf",  int'(res_ovf),  int'(e[4]));
                check("acc",      int'(acc),      int'(e[3:0]));
            end
        end
    end

    // Entered just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic ua, input logic [3:0] ed, input logic eo, input bit track);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_a       = a;
        cmd_b       = b;
        cmd_use_acc = ua;
        if (track) exp_q.push_back({eo, ed});
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (cmd_ready) begin
                @(posedge clk);
                #2;
                return;
            end
        end
        check("cmd_accept_timeout", 0, 1);
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        cmd_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_a = 4'h0; cmd_b = 4'h0;
        cmd_use_acc = 1'b0; res_ready = 1'b1; clr_sticky = 1'b0;
        cycles(2);
        @(negedge clk);
        check("reset_cmd_ready_low", int'(cmd_ready), 0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("reset_cmd_ready", int'(cmd_ready), 1);
        check("reset_res_valid", int'(res_valid), 0);
        check("reset_res_data", int'(res_data), 0);
        check("reset_res_ovf", int'(res_ovf), 0);
        check("reset_acc", int'(acc), 0);
        check("reset_sticky", int'(sticky_ovf), 0);
        check("reset_alu_a", int'(alu_a), 0);
        check("reset_alu_b", int'(alu_b), 0);
        check("reset_alu_op", int'(alu_op), 0);
        @(posedge clk); #2;

        // Single ADD 4+3: result valid two edges after acceptance.
        send(OP_ADD, 4'b0100, 4'b0011, 1'b0, 4'b0111, 1'b0, 1'b1);
        idle();
        @(negedge clk);
        check("lat_e0_res_valid", int'(res_valid), 0);
        @(negedge clk);
        check("lat_e1_res_valid", int'(res_valid), 0);
        check("lat_e1_alu_a", int'(alu_a), 4);
        check("lat_e1_alu_b", int'(alu_b), 3);
        @(negedge clk);
        check("lat_e2_res_valid", int'(res_valid), 1);
        check("lat_e2_acc", int'(acc), 7);
        @(posedge clk); #2;

        // ADD 12+5 overflows; sticky sets, then clears on pulse.
        send(OP_ADD, 4'd12, 4'd5, 1'b0, 4'b0001, 1'b1, 1'b1);
        idle();
        cycles(2);
        check("sticky_set", int'(sticky_ovf), 1);
        clr_sticky = 1'b1;
        cycles(1);
        clr_sticky = 1'b0;
        check("sticky_clear", int'(sticky_ovf), 0);

        // Chained accumulator use on back-to-back edges; cmd_a is junk when use_acc=1.
        send(OP_ADD, 4'd4, 4'd3, 1'b0, 4'd7, 1'b0, 1'b1);
        send(OP_SUB, 4'hF, 4'd4, 1'b1, 4'd3, 1'b0, 1'b1);
        send(OP_OR,  4'hF, 4'b1000, 1'b1, 4'b1011, 1'b0, 1'b1);
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("chain_res_valid", int'(res_valid), 1);
        end
        @(negedge clk);
        check("chain_done_res_valid", int'(res_valid), 0);
        @(posedge clk); #2;

        // Backpressure: six commands fill result reg, operand reg and FIFO.
        res_ready = 1'b0;
        send(OP_ADD, 4'd1, 4'd1, 1'b0, 4'd2, 1'b0, 1'b1);
        send(OP_ADD, 4'd2, 4'd2, 1'b0, 4'd4, 1'b0, 1'b1);
        send(OP_AND, 4'hF, 4'd3, 1'b0, 4'd3, 1'b0, 1'b1);
        send(OP_OR,  4'd1, 4'd2, 1'b0, 4'd3, 1'b0, 1'b1);
        send(OP_SUB, 4'd0, 4'd1, 1'b0, 4'hF, 1'b0, 1'b1);
        send(OP_ADD, 4'd8, 4'd8, 1'b0, 4'd0, 1'b1, 1'b1);
        idle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("bp_cmd_ready", int'(cmd_ready), 0);
            check("bp_res_valid", int'(res_valid), 1);
            check("bp_res_data_held", int'(res_data), 2);
            check("bp_alu_a_held", int'(alu_a), 2);
        end
        @(posedge clk); #2;
        res_ready = 1'b1;
        cycles(10);
        check("bp_drained", exp_q.size(), 0);
        check("bp_sticky", int'(sticky_ovf), 1);

        // Logic ops and SUB: overflow masked to 0.
        send(OP_AND, 4'b1010, 4'b1100, 1'b0, 4'b1000, 1'b0, 1'b1);
        send(OP_OR,  4'b1010, 4'b1100, 1'b0, 4'b1110, 1'b0, 1'b1);
        send(OP_SUB, 4'b1010, 4'b0100, 1'b0, 4'b0110, 1'b0, 1'b1);
        idle();
        cycles(5);
        check("logic_drained", exp_q.size(), 0);

        // Reset while stalled with a full FIFO: everything is discarded.
        res_ready = 1'b0;
        send(OP_ADD, 4'd3, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0);
        send(OP_ADD, 4'd9, 4'd9, 1'b0, 4'd0, 1'b0, 1'b0);
        send(OP_SUB, 4'd5, 4'd1, 1'b0, 4'd0, 1'b0, 1'b0);
        send(OP_OR,  4'd5, 4'd1, 1'b0, 4'd0, 1'b0, 1'b0);
        send(OP_AND, 4'd5, 4'd1, 1'b0, 4'd0, 1'b0, 1'b0);
        send(OP_ADD, 4'd1, 4'd1, 1'b0, 4'd0, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        check("stall_full_cmd_ready", int'(cmd_ready), 0);
        @(posedge clk); #2;
        rst = 1'b1;
        res_ready = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_res_valid", int'(res_valid), 0);
        check("mid_rst_acc", int'(acc), 0);
        check("mid_rst_cmd_ready", int'(cmd_ready), 1);
        check("mid_rst_sticky", int'(sticky_ovf), 0);
        @(posedge clk); #2;
        cycles(6);
        check("mid_rst_no_result", int'(res_valid), 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
